// File: rtl/usb_ft1248_pkg.sv
// usb_ft1248_pkg: command codes and FSM states shared by FT1248 device and host controller
package usb_ft1248_pkg;
  localparam logic [7:0] CMD_WRITE = 8'h00;
  localparam logic [7:0] CMD_READ  = 8'h04;
  typedef enum logic [2:0] {IDLE, CMD_LO, CMD_HI, TURN, ACK, DATA_LO, DATA_HI, DONE} ft_state_e;
endpackage

// File: rtl/usb_ft1248_sync.sv
// usb_ft1248_sync: multi-stage synchronizer for a data bus plus one edge-detected clock line
// Ports: clk/reset_n system side; e_i async clock line, d_i async bus;
//        q_o synchronized bus, vld_o high once the pipeline holds real samples,
//        rise_o/fall_o one-clk pulses on synchronized e_i edges.
module usb_ft1248_sync #(
  parameter int              STAGES  = 2,
  parameter int              W       = 5,
  parameter logic [W-1:0]    RST_VAL = '0
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         e_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o,
  output logic         vld_o,
  output logic         rise_o,
  output logic         fall_o
);
  logic [W:0]        stg_q [STAGES];
  logic [STAGES-1:0] fill_q;
  logic              prev_q;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < STAGES; i++) stg_q[i] <= {RST_VAL, 1'b0};
      fill_q <= '0;
      prev_q <= 1'b0;
    end else begin
      stg_q[0] <= {d_i, e_i};
      for (int i = 1; i < STAGES; i++) stg_q[i] <= stg_q[i-1];
      fill_q <= {fill_q, 1'b1};
      prev_q <= stg_q[STAGES-1][0];
    end
  end
  assign q_o    = stg_q[STAGES-1][W:1];
  assign vld_o  = fill_q[STAGES-1];
  assign rise_o = stg_q[STAGES-1][0] & ~prev_q;
  assign fall_o = ~stg_q[STAGES-1][0] & prev_q;
endmodule

// File: rtl/usb_ft1248_device.sv
// usb_ft1248_device: FT1248 device-side bus slave bridging a host to rx/tx byte FIFOs
// Ports: clk/reset_n system clock and sync active-low reset; usb_clk/usb_cs/usb_miso/usb_miosi
//        FT1248 bus; rx_full/rx_write/rx_wdata host-to-device FIFO push side;
//        tx_empty/tx_read/tx_rdata device-to-host FIFO pop side; cmd_error unsupported command pulse.
module usb_ft1248_device
  import usb_ft1248_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       usb_clk,
  input  logic       usb_cs,
  output logic       usb_miso,
  inout  wire  [3:0] usb_miosi,
  input  logic       rx_full,
  output logic       rx_write,
  output logic [7:0] rx_wdata,
  input  logic       tx_empty,
  output logic       tx_read,
  input  logic [7:0] tx_rdata,
  output logic       cmd_error
);
  ft_state_e  state_q, state_d;
  logic [4:0] sync_q;
  logic       vld, clk_rise, clk_fall, cs_s, stop;
  logic [3:0] nib_s, nib_q, nib_d, dout_q, dout_d;
  logic [7:0] cmd, rx_wdata_q, rx_wdata_d;
  logic       dir_q, dir_d, armed_q, armed_d, miso_q, miso_d, oe_q, oe_d;
  logic       rx_write_q, rx_write_d, tx_read_q, tx_read_d, cmd_error_q, cmd_error_d;
  usb_ft1248_sync #(.STAGES(SYNC_STAGES), .W(5), .RST_VAL(5'b00001)) u_sync (
    .clk    (clk),
    .reset_n(reset_n),
    .e_i    (usb_clk),
    .d_i    ({usb_miosi, usb_cs}),
    .q_o    (sync_q),
    .vld_o  (vld),
    .rise_o (clk_rise),
    .fall_o (clk_fall)
  );
  assign cs_s  = sync_q[0];
  assign nib_s = sync_q[4:1];
  assign cmd   = {nib_s, nib_q};
  // dir_q: 1 = host read (tx), 0 = host write (rx); stop means the FIFO cannot take/give a byte
  assign stop  = dir_q ? tx_empty : rx_full;
  always_comb begin
    state_d     = state_q;
    dir_d       = dir_q;
    nib_d       = nib_q;
    armed_d     = armed_q | (cs_s & vld);
    miso_d      = miso_q;
    oe_d        = oe_q;
    dout_d      = dout_q;
    rx_write_d  = 1'b0;
    rx_wdata_d  = rx_wdata_q;
    tx_read_d   = 1'b0;
    cmd_error_d = 1'b0;
    case (state_q)
      IDLE: begin
        miso_d = 1'b1;
        oe_d   = 1'b0;
        if (armed_q && vld && !cs_s) begin
          state_d = CMD_LO;
          armed_d = 1'b0;
        end
      end
      CMD_LO: if (clk_rise) begin
        nib_d   = nib_s;
        state_d = CMD_HI;
      end
      CMD_HI: if (clk_rise) begin
        dir_d       = cmd == CMD_READ;
        cmd_error_d = cmd != CMD_READ && cmd != CMD_WRITE;
        state_d     = cmd_error_d ? DONE : TURN;
      end
      TURN: if (clk_rise) state_d = ACK;
      ACK: begin
        if (clk_fall) miso_d = stop;
        if (clk_rise) state_d = miso_q ? DONE : DATA_LO;
      end
      // Each fall in DATA_LO re-evaluates flow control and presents the next low nibble
      DATA_LO: begin
        if (clk_fall) begin
          miso_d = stop;
          oe_d   = dir_q && !stop;
          dout_d = tx_rdata[3:0];
        end
        if (clk_rise) begin
          nib_d   = nib_s;
          state_d = miso_q ? DONE : DATA_HI;
        end
      end
      DATA_HI: begin
        if (clk_fall) dout_d = tx_rdata[7:4];
        if (clk_rise) begin
          state_d    = DATA_LO;
          tx_read_d  = dir_q;
          rx_write_d = !dir_q;
          rx_wdata_d = dir_q ? rx_wdata_q : cmd;
        end
      end
      DONE: begin
        miso_d  = 1'b1;
        oe_d    = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Host deselect aborts the transfer; any byte in flight is dropped
    if (cs_s && !(state_q inside {IDLE, DONE})) begin
      state_d     = DONE;
      miso_d      = 1'b1;
      oe_d        = 1'b0;
      rx_write_d  = 1'b0;
      rx_wdata_d  = rx_wdata_q;
      tx_read_d   = 1'b0;
      cmd_error_d = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      dir_q       <= 1'b0;
      nib_q       <= '0;
      armed_q     <= 1'b0;
      miso_q      <= 1'b1;
      oe_q        <= 1'b0;
      dout_q      <= '0;
      rx_write_q  <= 1'b0;
      rx_wdata_q  <= '0;
      tx_read_q   <= 1'b0;
      cmd_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      nib_q       <= nib_d;
      armed_q     <= armed_d;
      miso_q      <= miso_d;
      oe_q        <= oe_d;
      dout_q      <= dout_d;
      rx_write_q  <= rx_write_d;
      rx_wdata_q  <= rx_wdata_d;
      tx_read_q   <= tx_read_d;
      cmd_error_q <= cmd_error_d;
    end
  end
  assign usb_miosi = oe_q ? dout_q : 4'bz;
  assign usb_miso  = miso_q;
  assign rx_write  = rx_write_q;
  assign rx_wdata  = rx_wdata_q;
  assign tx_read   = tx_read_q;
  assign cmd_error = cmd_error_q;
endmodule

// File: tb/tb_usb_ft1248_device.sv
// tb_usb_ft1248_device: directed FT1248 host transactions against the device with FIFO models
module tb_usb_ft1248_device;
  logic       clk = 0, reset_n = 0, usb_clk = 0, usb_cs = 1;
  logic       usb_miso, rx_full, rx_write, tx_empty, tx_read, cmd_error;
  logic [7:0] rx_wdata, tx_rdata;
  wire  [3:0] usb_miosi;
  logic       host_oe = 0;
  logic [3:0] host_nib = 0;
  logic [7:0] tx_mem [16];
  logic [7:0] rx_log [16];
  logic [3:0] tx_ptr = 0, tx_top = 0;
  logic       full_on = 0;
  int         full_base = 0, rx_cnt = 0, tx_cnt = 0, err_clks = 0, both_clks = 0, oe_clks = 0;
  int         checks = 0, errors = 0, oe_base;
  logic [3:0] mi;
  logic       mo, oe, ack;
  assign usb_miosi = host_oe ? host_nib : 4'bz;
  assign tx_empty  = tx_ptr == tx_top;
  assign tx_rdata  = tx_mem[tx_ptr];
  assign rx_full   = full_on && rx_cnt > full_base;
  always #5 clk = ~clk;
  usb_ft1248_device #(.SYNC_STAGES(2)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .usb_clk  (usb_clk),
    .usb_cs   (usb_cs),
    .usb_miso (usb_miso),
    .usb_miosi(usb_miosi),
    .rx_full  (rx_full),
    .rx_write (rx_write),
    .rx_wdata (rx_wdata),
    .tx_empty (tx_empty),
    .tx_read  (tx_read),
    .tx_rdata (tx_rdata),
    .cmd_error(cmd_error)
  );
  always @(posedge clk) begin
    if (rx_write) begin
      rx_log[rx_cnt[3:0]] <= rx_wdata;
      rx_cnt <= rx_cnt + 1;
    end
    if (tx_read) begin
      tx_ptr <= tx_ptr + 4'd1;
      tx_cnt <= tx_cnt + 1;
    end
    if (cmd_error) err_clks <= err_clks + 1;
    if (rx_write && tx_read) both_clks <= both_clks + 1;
    if (dut.oe_q) oe_clks <= oe_clks + 1;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // One usb_clk period: host presents nibble in low phase, samples device just before the rise
  task automatic tick(input logic [3:0] n, input logic drv, output logic [3:0] m_i, output logic m_o, output logic o_e);
    host_nib = n;
    host_oe  = drv;
    #80;
    m_i = usb_miosi;
    m_o = usb_miso;
    o_e = dut.oe_q;
    usb_clk = 1;
    #80;
    usb_clk = 0;
  endtask
  task automatic command(input logic [7:0] c, output logic a);
    logic [3:0] t_mi;
    logic       t_mo, t_oe;
    usb_cs = 0;
    tick(c[3:0], 1, t_mi, t_mo, t_oe);
    tick(c[7:4], 1, t_mi, t_mo, t_oe);
    tick(4'h0, 0, t_mi, t_mo, t_oe);
    tick(4'h0, 0, t_mi, a, t_oe);
  endtask
  task automatic end_xfer();
    host_oe = 0;
    usb_cs  = 1;
    #100;
  endtask
  initial begin
    for (int i = 0; i < 16; i++) tx_mem[i] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_miso", usb_miso, 1);
    check("rst_oe", dut.oe_q, 0);
    check("rst_rx_write", rx_write, 0);
    check("rst_tx_read", tx_read, 0);
    check("rst_cmd_error", cmd_error, 0);
    check("rst_rx_wdata", rx_wdata, 0);
    reset_n = 1;
    #100;
    command(8'h00, ack);
    check("w_ack", ack, 0);
    tick(4'h5, 1, mi, mo, oe);
    tick(4'hA, 1, mi, mo, oe);
    tick(4'hC, 1, mi, mo, oe);
    check("w_cont", mo, 0);
    tick(4'h3, 1, mi, mo, oe);
    end_xfer();
    check("w_cnt", rx_cnt, 2);
    check("w_b0", rx_log[0], 8'hA5);
    check("w_b1", rx_log[1], 8'h3C);
    tx_mem[tx_ptr] = 8'h12;
    tx_mem[4'(tx_ptr + 4'd1)] = 8'h34;
    tx_top = 4'(tx_ptr + 4'd2);
    command(8'h04, ack);
    check("r_ack", ack, 0);
    tick(4'h0, 0, mi, mo, oe);
    check("r_n0", mi, 4'h2);
    check("r_oe", oe, 1);
    tick(4'h0, 0, mi, mo, oe);
    check("r_n1", mi, 4'h1);
    tick(4'h0, 0, mi, mo, oe);
    check("r_n2", mi, 4'h4);
    check("r_cont", mo, 0);
    tick(4'h0, 0, mi, mo, oe);
    check("r_n3", mi, 4'h3);
    tick(4'h0, 0, mi, mo, oe);
    check("r_stop", mo, 1);
    check("r_stop_oe", oe, 0);
    end_xfer();
    check("r_tx_cnt", tx_cnt, 2);
    oe_base = oe_clks;
    command(8'h04, ack);
    check("e_nak", ack, 1);
    end_xfer();
    check("e_no_drive", oe_clks, oe_base);
    check("e_tx_cnt", tx_cnt, 2);
    command(8'h55, ack);
    check("c_nak", ack, 1);
    end_xfer();
    check("c_err", err_clks, 1);
    check("c_rx_cnt", rx_cnt, 2);
    check("c_tx_cnt", tx_cnt, 2);
    full_base = rx_cnt;
    full_on = 1;
    command(8'h00, ack);
    check("f_ack", ack, 0);
    tick(4'hE, 1, mi, mo, oe);
    tick(4'h7, 1, mi, mo, oe);
    tick(4'h0, 1, mi, mo, oe);
    check("f_stop", mo, 1);
    end_xfer();
    full_on = 0;
    check("f_cnt", rx_cnt, 3);
    check("f_b0", rx_log[2], 8'h7E);
    command(8'h00, ack);
    check("a_ack", ack, 0);
    tick(4'h1, 1, mi, mo, oe);
    tick(4'h2, 1, mi, mo, oe);
    tick(4'h3, 1, mi, mo, oe);
    check("a_cont", mo, 0);
    usb_cs = 1;
    host_oe = 0;
    repeat (3) @(posedge clk);
    #1;
    check("a_miso", usb_miso, 1);
    #100;
    check("a_cnt", rx_cnt, 4);
    check("a_b0", rx_log[3], 8'h21);
    tx_mem[tx_ptr] = 8'h9A;
    tx_mem[4'(tx_ptr + 4'd1)] = 8'hBC;
    tx_top = 4'(tx_ptr + 4'd2);
    command(8'h04, ack);
    check("x_ack", ack, 0);
    tick(4'h0, 0, mi, mo, oe);
    check("x_n0", mi, 4'hA);
    check("x_oe_on", oe, 1);
    reset_n = 0;
    repeat (3) @(posedge clk);
    #1;
    check("x_oe_off", dut.oe_q, 0);
    check("x_miso", usb_miso, 1);
    reset_n = 1;
    tick(4'h0, 0, mi, mo, oe);
    tick(4'h0, 0, mi, mo, oe);
    check("x_idle_oe", oe, 0);
    check("x_idle_miso", mo, 1);
    check("x_tx_cnt", tx_cnt, 2);
    end_xfer();
    command(8'h00, ack);
    check("v_ack", ack, 0);
    tick(4'hA, 1, mi, mo, oe);
    tick(4'h5, 1, mi, mo, oe);
    end_xfer();
    check("v_cnt", rx_cnt, 5);
    check("v_b0", rx_log[4], 8'h5A);
    check("v_tx_cnt", tx_cnt, 2);
    check("v_err", err_clks, 1);
    check("v_both", both_clks, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
